// File: rtl/masked_concat_pipe.sv
// Forms {hi, ~lo}, combines it with mask by mode, and carries it through a DEPTH-stage valid/ready pipe.
// Latency DEPTH-1 edges from accept to out_valid; ready chain is combinational from out_ready, stalls hold data.
module masked_concat_pipe #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH/2-1:0]     hi,
  input  logic [WIDTH/2-1:0]     lo,
  input  logic [WIDTH-1:0]       mask,
  input  logic [1:0]             mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_zero,
  input  logic                   count_clr,
  output logic [CNT_W-1:0]       match_count
);

  localparam logic [1:0] MODE_AND  = 2'b00;
  localparam logic [1:0] MODE_OR   = 2'b01;
  localparam logic [1:0] MODE_XOR  = 2'b10;

  logic [WIDTH-1:0] concat;
  logic [WIDTH-1:0] result;

  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0]             valid_d;
  logic [DEPTH-1:0][WIDTH-1:0]  data_q;
  logic [DEPTH-1:0][WIDTH-1:0]  data_d;
  logic [DEPTH-1:0]             load;
  logic [DEPTH-1:0]             src_vld;
  logic [DEPTH-1:0][WIDTH-1:0]  src_dat;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             xfer_out;
  logic             cnt_inc;

  assign concat = {hi, ~lo};

  always_comb begin
    result = concat;
    case (mode)
      MODE_AND: result = concat & mask;
      MODE_OR:  result = concat | mask;
      MODE_XOR: result = concat ^ mask;
      default:  result = concat;
    endcase
  end

  // A stage may load if it or any stage downstream of it is empty, or the output drains.
  always_comb begin
    logic empty_below;
    empty_below = 1'b0;
    load        = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      empty_below = empty_below | ~valid_q[k];
      load[k]     = empty_below | out_ready;
    end
  end

  assign src_vld[0] = in_valid;
  assign src_dat[0] = result;

  for (genvar k = 1; k < DEPTH; k++) begin : g_src
    assign src_vld[k] = valid_q[k-1];
    assign src_dat[k] = data_q[k-1];
  end

  // Bubbles propagate as invalid but leave the previous data in place.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (load[k]) begin
        valid_d[k] = src_vld[k];
        if (src_vld[k]) begin
          data_d[k] = src_dat[k];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = load[0];
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_zero  = valid_q[DEPTH-1] && (data_q[DEPTH-1] == '0);

  assign xfer_out = valid_q[DEPTH-1] && out_ready;
  assign cnt_inc  = xfer_out && (data_q[DEPTH-1] != '0);

  // Clear takes priority over a coincident increment; the counter sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (count_clr) begin
      cnt_d = '0;
    end else if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_count = cnt_q;

endmodule

// File: tb/tb_masked_concat_pipe.sv
// Scoreboard bench for masked_concat_pipe (WIDTH=8, DEPTH=3, CNT_W=2): random and directed traffic.
module tb_masked_concat_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       hi = '0;
  logic [3:0]       lo = '0;
  logic [7:0]       mask = '0;
  logic [1:0]       mode = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_data;
  logic             out_zero;
  logic             count_clr = 1'b0;
  logic [CNT_W-1:0] match_count;

  masked_concat_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .hi(hi), .lo(lo), .mask(mask), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero),
    .count_clr(count_clr), .match_count(match_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_acc = 0;
  int model_cnt = 0;
  logic [7:0] exp_dat_q[$];
  int         exp_acc_q[$];

  always @(posedge clock) cyc++;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // {hi, ~lo} as plain arithmetic, then the selected bitwise operator.
  function automatic logic [7:0] ref_model(logic [3:0] h, logic [3:0] l, logic [7:0] m, logic [1:0] md);
    logic [7:0] c;
    c = 8'(h) * 8'd16 + (8'd15 - 8'(l));
    case (md)
      2'd0:    return c & m;
      2'd1:    return c | m;
      2'd2:    return c ^ m;
      default: return c;
    endcase
  endfunction

  // Input monitor: record each accepted transaction with the edge that will capture it.
  initial forever begin
    @(negedge clock);
    #2;
    if (!reset && in_valid && in_ready) begin
      exp_dat_q.push_back(ref_model(hi, lo, mask, mode));
      exp_acc_q.push_back(cyc + 1);
      n_acc++;
    end
  end

  // Output monitor: the oldest in-flight item is at the output once DEPTH-1 edges have passed.
  initial forever begin
    logic       exp_v;
    logic [7:0] head;
    @(negedge clock);
    if (!reset) begin
      exp_v = (exp_dat_q.size() > 0) && (cyc - exp_acc_q[0] >= DEPTH - 1);
      head  = (exp_dat_q.size() > 0) ? exp_dat_q[0] : 8'h00;
      check("in_ready", 32'(in_ready), 32'((exp_dat_q.size() < DEPTH) || out_ready));
      check("match_count", 32'(match_count), 32'(model_cnt));
      check("out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v) begin
        check("out_data", 32'(out_data), 32'(head));
        check("out_zero", 32'(out_zero), 32'(head == 8'h00));
      end else begin
        check("out_zero_idle", 32'(out_zero), 32'(0));
      end
      if (count_clr) model_cnt = 0;
      else if (exp_v && out_ready && head != 8'h00 && model_cnt < CNT_MAX) model_cnt++;
      if (exp_v && out_ready) begin
        void'(exp_dat_q.pop_front());
        void'(exp_acc_q.pop_front());
      end
    end
  end

  task automatic drive(logic v, logic [3:0] h, logic [3:0] l, logic [7:0] m, logic [1:0] md,
                       logic ordy, logic clr);
    @(posedge clock);
    #1;
    in_valid = v; hi = h; lo = l; mask = m; mode = md; out_ready = ordy; count_clr = clr;
  endtask

  task automatic drive_rand(logic v, logic ordy, logic clr);
    drive(v, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), ordy, clr);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    drive_rand(1'b0, 1'b1, 1'b0);
    while (exp_dat_q.size() > 0 && budget < 40) begin
      drive_rand(1'b0, 1'b1, 1'b0);
      budget++;
    end
    @(negedge clock);
    #3;
    check("drain_timeout", 32'(exp_dat_q.size()), 32'(0));
  endtask

  task automatic check_reset_state(string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_out_data"}, 32'(out_data), 32'(0));
    check({tag, "_out_zero"}, 32'(out_zero), 32'(0));
    check({tag, "_match_count"}, 32'(match_count), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int acc0;
    int idx;
    logic [3:0] bh[5];
    logic [3:0] bl[5];
    logic [7:0] bm[5];

    // Power-on reset.
    repeat (2) @(posedge clock);
    #1;
    check_reset_state("rst");
    #2;
    reset = 1'b0;

    // Mode sweep on {A, ~3} = AC with mask 0F.
    for (int md = 0; md < 4; md++) drive(1'b1, 4'hA, 4'h3, 8'h0F, 2'(md), 1'b1, 1'b0);
    drain();

    // Zero and all-ones results back to back.
    drive(1'b1, 4'h0, 4'hF, 8'hFF, 2'd0, 1'b1, 1'b0);
    drive(1'b1, 4'hF, 4'h0, 8'h00, 2'd1, 1'b1, 1'b0);
    drain();

    // Random traffic with random back-pressure and occasional clears.
    for (int c = 0; c < 400; c++)
      drive_rand(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 31) == 0));
    drain();

    // Back-pressure: five transactions offered into a stalled pipe.
    for (int i = 0; i < 5; i++) begin
      bh[i] = 4'($urandom_range(1, 15));
      bl[i] = 4'($urandom_range(0, 15));
      bm[i] = 8'($urandom_range(0, 255));
    end
    acc0 = n_acc;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock);
      #1;
      out_ready = (c >= 6);
      count_clr = 1'b0;
      if (idx < 5) begin
        in_valid = 1'b1; hi = bh[idx]; lo = bl[idx]; mask = bm[idx]; mode = 2'd3;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clock);
      #1;
      if (c == 4) check("bp_in_ready_low", 32'(in_ready), 32'(0));
      if (c == 5) check("bp_accepted", 32'(n_acc - acc0), 32'(3));
      if (in_valid && in_ready) idx++;
    end
    check("bp_all_accepted", 32'(idx), 32'(5));
    drain();

    // Saturation: six non-zero results, clear coinciding with the sixth transfer.
    drive_rand(1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 12; c++) begin
      drive(1'(c < 6), 4'hF, 4'($urandom_range(0, 15)), 8'h00, 2'd3, 1'b1, 1'(c == 8));
      @(negedge clock);
      #1;
      if (c == 8) check("sat_hold", 32'(match_count), 32'(CNT_MAX));
      if (c == 9) check("sat_clr_wins", 32'(match_count), 32'(0));
    end
    drain();

    // Build up a non-zero count, then reset with two transactions in flight.
    for (int c = 0; c < 4; c++) drive(1'b1, 4'h5, 4'h0, 8'h00, 2'd3, 1'b1, 1'b0);
    drain();
    drive(1'b1, 4'h1, 4'h2, 8'h00, 2'd3, 1'b1, 1'b0);
    drive(1'b1, 4'h3, 4'h4, 8'h00, 2'd3, 1'b1, 1'b0);
    @(posedge clock);
    #3;
    reset = 1'b1;
    in_valid = 1'b0;
    exp_dat_q.delete();
    exp_acc_q.delete();
    model_cnt = 0;
    #1;
    check_reset_state("midrst");
    @(posedge clock);
    @(posedge clock);
    #3;
    reset = 1'b0;
    drive(1'b1, 4'h9, 4'h6, 8'hF0, 2'd2, 1'b1, 1'b0);
    drain();

    // Bubbles: alternating in_valid with a free-running output.
    for (int c = 0; c < 20; c++) drive_rand(1'(c % 2 == 0), 1'b1, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
